// File: rtl/cgra_apb_master.sv
// APB3 initiator: converts single-beat valid/ready commands into SETUP/ACCESS
// transfers, with misaligned-address rejection and an optional wait-state timeout.
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready high
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1 until pready or timeout
// RESP   | response held on rsp_* until rsp_ready
module cgra_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  busy,
    output logic                  timeout_flag
);

    // A zero timeout still needs a legal (1-bit) counter even though it is never compared.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]      CNT_MAX       = '1;
    localparam logic [CNT_W-1:0]      CNT_LIMIT     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_RDATA = DATA_WIDTH'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  timeout_flag_q, timeout_flag_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wait_cnt_q     <= '0;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            paddr_q        <= '0;
            pwdata_q       <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            psel_q         <= psel_d;
            penable_q      <= penable_d;
            pwrite_q       <= pwrite_d;
            paddr_q        <= paddr_d;
            pwdata_q       <= pwdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        psel_d         = psel_q;
        penable_d      = penable_q;
        pwrite_d       = pwrite_q;
        paddr_d        = paddr_q;
        pwdata_d       = pwdata_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_err_d      = rsp_err_q;
        timeout_flag_d = timeout_flag_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d       = cmd_write;
                    paddr_d        = cmd_addr;
                    pwdata_d       = cmd_wdata;
                    timeout_flag_d = 1'b0;
                    if (cmd_addr[1:0] != 2'b00) begin
                        // Misaligned: answer with an error and never touch the bus.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = S_SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                    end
                end
            end

            S_SETUP: begin
                state_d    = S_ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end

            S_ACCESS: begin
                if (pready) begin
                    state_d     = S_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                end else begin
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                    // Abort on the wait cycle that brings the count to the limit.
                    if ((TIMEOUT_CYCLES != 0) && (wait_cnt_d == CNT_LIMIT)) begin
                        state_d        = S_RESP;
                        psel_d         = 1'b0;
                        penable_d      = 1'b0;
                        rsp_valid_d    = 1'b1;
                        rsp_rdata_d    = TIMEOUT_RDATA;
                        rsp_err_d      = 1'b1;
                        timeout_flag_d = 1'b1;
                    end
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign psel         = psel_q;
    assign penable      = penable_q;
    assign pwrite       = pwrite_q;
    assign paddr        = paddr_q;
    assign pwdata       = pwdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_cgra_apb_master.sv
// Directed bench for cgra_apb_master: table of transfers against a small
// wait-state CSR slave, plus reset-during-ACCESS sequence.
module tb_cgra_apb_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        busy;
    logic        timeout_flag;

    int n_checks = 0;
    int n_fail   = 0;

    cgra_apb_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .busy        (busy),
        .timeout_flag(timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR slave: answers after wait_states ACCESS cycles; word i resets to 0xA500_00ii.
    int          wait_states = 0;
    logic        slave_err   = 1'b0;
    logic [31:0] mem [64];
    logic        mem_init = 1'b0;
    int          acc_cnt  = 0;

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
            mem_init = 1'b1;
        end
        if (psel && penable) begin
            pready = (acc_cnt >= wait_states);
            acc_cnt++;
            if (pready && pwrite) mem[paddr[7:2]] = pwdata;
        end else begin
            pready  = 1'b0;
            acc_cnt = 0;
        end
        prdata  = mem[paddr[7:2]];
        pslverr = slave_err && pready;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        serr;
        int          rdy_delay;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_pen;
        logic        exp_tflag;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        int          lat;
        int          pen_cycles;
        logic        psel_seen;
        logic        addr_moved;
        logic        got;
        logic [31:0] addr0;
        logic [31:0] held_rdata;
        wait_states = v.waits;
        slave_err   = v.serr;
        psel_seen   = 1'b0;
        addr_moved  = 1'b0;
        got         = 1'b0;
        pen_cycles  = 0;
        addr0       = '0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0000_003C;
        chk("accept_busy", busy, 1);
        chk("accept_cmd_ready", cmd_ready, 0);
        chk("accept_tflag_clear", timeout_flag, 0);
        lat = 1;
        while (lat < 40) begin
            if (psel) begin
                if (!psel_seen) addr0 = paddr;
                else if (paddr !== addr0) addr_moved = 1'b1;
                psel_seen = 1'b1;
            end
            if (penable) pen_cycles++;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        chk("rsp_arrived", got, 1);
        chk("rsp_latency", lat, v.exp_lat);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_tflag", timeout_flag, v.exp_tflag);
        chk("penable_cycles", pen_cycles, v.exp_pen);
        chk("psel_seen", psel_seen, (v.addr[1:0] == 2'b00));
        chk("paddr_stable", addr_moved, 0);
        if (psel_seen) chk("paddr_value", addr0, v.addr);
        held_rdata = rsp_rdata;
        // Offer a new command while busy; it must be ignored.
        cmd_valid = (v.rdy_delay > 0);
        for (int k = 0; k < v.rdy_delay; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, held_rdata);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_psel", psel, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_tflag", timeout_flag, v.exp_tflag);
    endtask

    initial begin
        // write addr wdata waits serr rdy_delay exp_rdata exp_err exp_lat exp_pen exp_tflag
        vecs[0] = '{1'b1, 32'h08, 32'h1000_0000, 0,    1'b0, 0, 32'h0,          1'b0, 3,  1,  1'b0};
        vecs[1] = '{1'b0, 32'h08, 32'h0,         0,    1'b0, 0, 32'h1000_0000,  1'b0, 3,  1,  1'b0};
        vecs[2] = '{1'b0, 32'h24, 32'h0,         3,    1'b0, 0, 32'hA500_0009,  1'b0, 6,  4,  1'b0};
        vecs[3] = '{1'b1, 32'h0C, 32'hCAFE_F00D, 0,    1'b1, 0, 32'h0,          1'b1, 3,  1,  1'b0};
        vecs[4] = '{1'b0, 32'h0A, 32'h0,         0,    1'b0, 0, 32'h0,          1'b1, 1,  0,  1'b0};
        vecs[5] = '{1'b0, 32'h10, 32'h0,         1,    1'b0, 5, 32'hA500_0004,  1'b0, 4,  2,  1'b0};
        vecs[6] = '{1'b0, 32'h30, 32'h0,         1000, 1'b0, 2, 32'hDEAD_BEEF,  1'b1, 18, 16, 1'b1};
        vecs[7] = '{1'b1, 32'h14, 32'h1234_5678, 2,    1'b0, 0, 32'h0,          1'b0, 5,  3,  1'b0};
        vecs[8] = '{1'b0, 32'h14, 32'h0,         0,    1'b0, 0, 32'h1234_5678,  1'b0, 3,  1,  1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_psel", psel, 0);
        chk("reset_penable", penable, 0);
        chk("reset_pwrite", pwrite, 0);
        chk("reset_paddr", paddr, 0);
        chk("reset_pwdata", pwdata, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_tflag", timeout_flag, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset while the slave stalls in ACCESS: transfer dropped, no response.
        wait_states = 1000;
        slave_err   = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_penable", penable, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_paddr", paddr, 0);
        begin
            logic stray;
            stray = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (rsp_valid || psel) stray = 1'b1;
            end
            chk("rst_no_response", stray, 0);
        end

        // Bus still usable afterwards.
        run_vec(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
